cirno_ctrl: RTL

- Multi-cycle sequencer for the Cirno core.
- Drives instruction fetch, the instruction decoder's enable, ALU, data memory, register writeback and PC update, one instruction at a time.
- Consumes the decoder's registered outputs (inst_type, branch, branchi, done) and handshakes with instruction and data memory.
- Detects halt, illegal inst_type and memory timeouts.

---
 rtl/cirno_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cirno_ctrl.sv
// Multi-cycle sequencer for the Cirno core: fetch, decode, execute, memory,
// writeback and PC update for one instruction at a time, with halt/fault detection.
module cirno_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int ICW         = 16
) (
  input  logic           clk,
  input  logic           init,
  input  logic           start,
  output logic           imem_req,
  input  logic           imem_ack,
  output logic           ir_load,
  output logic           decoder_en,
  input  logic [2:0]     inst_type,
  input  logic           branch,
  input  logic           branchi,
  input  logic           done,
  output logic           alu_en,
  output logic           dmem_rd,
  output logic           dmem_wr,
  input  logic           dmem_ack,
  output logic           reg_wr_en,
  output logic           pc_en,
  output logic [1:0]     pc_sel,
  output logic           busy,
  output logic           halted,
  output logic           fault,
  output logic [ICW-1:0] inst_count
);

  localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT, FAULT
  } state_t;

  state_t         state, next;
  logic [WW-1:0]  wcnt;
  logic           wait_expired;
  logic           is_store;
  logic [1:0]     sel_q;
  logic [1:0]     branch_sel;
  logic [ICW-1:0] count;

  // State register plus the small amount of per-instruction context.
  always_ff @(posedge clk) begin
    if (init) begin
      state    <= IDLE;
      wcnt     <= '0;
      is_store <= 1'b0;
      sel_q    <= '0;
      count    <= '0;
    end else begin
      state <= next;
      // Wait counter restarts on entry to a memory wait and advances only while stalled.
      if ((next != state) && ((next == FETCH) || (next == MEM)))
        wcnt <= '0;
      else if ((next == state) && ((state == FETCH) || (state == MEM)))
        wcnt <= wcnt + 1'b1;
      if (state == EXEC) begin
        is_store <= (inst_type == 3'd5);
        sel_q    <= branch_sel;
      end
      if (state == PCUPD)
        count <= count + 1'b1;
    end
  end

  always_comb begin
    next         = state;
    wait_expired = (wcnt == WW'(MEM_TIMEOUT));
    branch_sel   = 2'd0;
    case (inst_type)
      3'd2:    branch_sel = branchi ? 2'd1 : 2'd0;
      3'd3:    branch_sel = branch  ? 2'd2 : 2'd0;
      default: branch_sel = 2'd0;
    endcase
    if (init) begin
      next = IDLE;
    end else begin
      case (state)
        IDLE:   if (start) next = FETCH;
        FETCH: begin
          if (imem_ack)          next = DECODE;
          else if (wait_expired) next = FAULT;
        end
        DECODE: next = EXEC;
        EXEC: begin
          if (done) begin
            next = HALT;
          end else begin
            case (inst_type)
              3'd1, 3'd4: next = WB;
              3'd5, 3'd6: next = MEM;
              3'd2, 3'd3: next = PCUPD;
              default:    next = FAULT;
            endcase
          end
        end
        MEM: begin
          if (dmem_ack)          next = is_store ? PCUPD : WB;
          else if (wait_expired) next = FAULT;
        end
        WB:     next = PCUPD;
        PCUPD:  next = FETCH;
        HALT:   next = HALT;
        FAULT:  next = FAULT;
        default: next = FAULT;
      endcase
    end
  end

  // Outputs are forced low while init is asserted, whatever state is held.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    decoder_en = 1'b0;
    alu_en     = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    reg_wr_en  = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 2'd0;
    busy       = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    inst_count = '0;
    if (!init) begin
      inst_count = count;
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
          busy     = 1'b1;
        end
        DECODE: begin
          decoder_en = 1'b1;
          busy       = 1'b1;
        end
        EXEC: begin
          alu_en = !done && (inst_type == 3'd1);
          busy   = 1'b1;
        end
        MEM: begin
          dmem_wr = is_store;
          dmem_rd = !is_store;
          busy    = 1'b1;
        end
        WB: begin
          reg_wr_en = 1'b1;
          busy      = 1'b1;
        end
        PCUPD: begin
          pc_en  = 1'b1;
          pc_sel = sel_q;
          busy   = 1'b1;
        end
        HALT:    halted = 1'b1;
        FAULT:   fault  = 1'b1;
        default: busy   = 1'b0;
      endcase
    end
  end

endmodule
